// File: rtl/ldtu_link_pkg.sv
// rtl/ldtu_link_pkg.sv - shared state encoding, source select and default words for the link sequencer
package ldtu_link_pkg;

    localparam int          LANES         = 4;
    localparam logic [31:0] SYNC_WORD_DEF = 32'h5A5A_5A5A;
    localparam logic [31:0] IDLE_WORD_DEF = 32'hEAAA_AAAA;

    // Encoding is visible on the mode port and must not change.
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_DATA   = 2'd1,
        ST_TEST   = 2'd2,
        ST_SWITCH = 2'd3
    } link_state_e;

    typedef enum logic [1:0] {
        SRC_SYNC = 2'd0,
        SRC_DP   = 2'd1,
        SRC_ATU  = 2'd2,
        SRC_IDLE = 2'd3
    } lane_src_e;

endpackage

// File: rtl/ldtu_sync_frame_ctr.sv
// rtl/ldtu_sync_frame_ctr.sv - saturating 16-bit training frame counter with terminal flag
module ldtu_sync_frame_ctr #(
    parameter int unsigned SYNC_FRAMES = 64
) (
    input  logic clock,
    input  logic rst_b,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [15:0] count;

    // clr together with en restarts at 1: the restarting frame is itself a sync frame.
    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            count <= 16'd0;
        end else if (clr) begin
            count <= en ? 16'd1 : 16'd0;
        end else if (en && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    // High when the next enabled frame is the SYNC_FRAMES-th one (or beyond).
    assign term = (({16'd0, count} + 32'd1) >= SYNC_FRAMES);

endmodule

// File: rtl/ldtu_link_sequencer.sv
// rtl/ldtu_link_sequencer.sv - frame-aligned lane source sequencer; training enabled by LDTU_SYNC_TRAIN_EN
module ldtu_link_sequencer
    import ldtu_link_pkg::*;
#(
    parameter int unsigned      NBITS       = 32,
    parameter int unsigned      SYNC_FRAMES = 64,
    parameter logic [NBITS-1:0] SYNC_WORD   = NBITS'(SYNC_WORD_DEF),
    parameter logic [NBITS-1:0] IDLE_WORD   = NBITS'(IDLE_WORD_DEF)
) (
    input  logic             clock,
    input  logic             rst_b,
    input  logic             handshake,
    input  logic             test_enable,
    input  logic             resync,
    input  logic             dp_valid,
    input  logic [NBITS-1:0] DataIn0,
    input  logic [NBITS-1:0] DataIn1,
    input  logic [NBITS-1:0] DataIn2,
    input  logic [NBITS-1:0] DataIn3,
    input  logic [NBITS-1:0] DataAtu0,
    input  logic [NBITS-1:0] DataAtu1,
    input  logic [NBITS-1:0] DataAtu2,
    input  logic [NBITS-1:0] DataAtu3,
    output logic [NBITS-1:0] DataOut0,
    output logic [NBITS-1:0] DataOut1,
    output logic [NBITS-1:0] DataOut2,
    output logic [NBITS-1:0] DataOut3,
    output logic             dp_ack,
    output logic [1:0]       mode,
    output logic             idle_ins,
    output logic [15:0]      frame_cnt
);

`ifdef LDTU_SYNC_TRAIN_EN
    localparam link_state_e      RESET_STATE = ST_SYNC;
    localparam logic [NBITS-1:0] RESET_WORD  = SYNC_WORD;
`else
    localparam link_state_e      RESET_STATE = ST_DATA;
    localparam logic [NBITS-1:0] RESET_WORD  = IDLE_WORD;
`endif

    link_state_e state;
    link_state_e nxt_state;
    link_state_e tgt;
    lane_src_e   src;
    logic        ack_d;
    logic        idle_d;
    logic        armed;
    logic        hs_ok;
    logic        resync_hit;

    logic [NBITS-1:0] din  [LANES];
    logic [NBITS-1:0] atu  [LANES];
    logic [NBITS-1:0] dout [LANES];

    assign din[0] = DataIn0;
    assign din[1] = DataIn1;
    assign din[2] = DataIn2;
    assign din[3] = DataIn3;
    assign atu[0] = DataAtu0;
    assign atu[1] = DataAtu1;
    assign atu[2] = DataAtu2;
    assign atu[3] = DataAtu3;

    assign DataOut0 = dout[0];
    assign DataOut1 = dout[1];
    assign DataOut2 = dout[2];
    assign DataOut3 = dout[3];

    // armed masks the first edge after reset release so a coincident strobe is dropped.
    assign hs_ok = handshake && armed;
    assign tgt   = test_enable ? ST_TEST : ST_DATA;
    assign mode  = state;

`ifdef LDTU_SYNC_TRAIN_EN
    logic sync_term;

    assign resync_hit = resync && (state != ST_SYNC);

    ldtu_sync_frame_ctr #(
        .SYNC_FRAMES (SYNC_FRAMES)
    ) u_sync_ctr (
        .clock (clock),
        .rst_b (rst_b),
        .clr   (hs_ok && resync_hit),
        .en    (hs_ok && (resync_hit || state == ST_SYNC)),
        .term  (sync_term)
    );
`else
    logic unused_cfg;

    assign resync_hit = 1'b0;
    assign unused_cfg = &{1'b0, resync, 1'(SYNC_FRAMES)};
`endif

    // The frame loaded at a strobe already belongs to the state being entered.
    always_comb begin
        nxt_state = state;
        src       = SRC_IDLE;
        ack_d     = 1'b0;
        idle_d    = 1'b0;
`ifdef LDTU_SYNC_TRAIN_EN
        if (resync_hit) begin
            nxt_state = ST_SYNC;
            src       = SRC_SYNC;
        end else if (state == ST_SYNC) begin
            src = SRC_SYNC;
            if (sync_term) begin
                nxt_state = tgt;
            end
        end else
`endif
        if (state != ST_SWITCH && state != tgt) begin
            nxt_state = ST_SWITCH;
        end else begin
            nxt_state = tgt;
            if (tgt == ST_TEST) begin
                src = SRC_ATU;
            end else if (dp_valid) begin
                src   = SRC_DP;
                ack_d = 1'b1;
            end else begin
                idle_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            state     <= RESET_STATE;
            frame_cnt <= 16'd0;
            dp_ack    <= 1'b0;
            idle_ins  <= 1'b0;
            armed     <= 1'b0;
        end else begin
            armed    <= 1'b1;
            dp_ack   <= hs_ok && ack_d;
            idle_ins <= hs_ok && idle_d;
            if (hs_ok) begin
                state     <= nxt_state;
                frame_cnt <= resync_hit ? 16'd0 : frame_cnt + 16'd1;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [NBITS-1:0] word_q;

        always_ff @(posedge clock or negedge rst_b) begin
            if (!rst_b) begin
                word_q <= RESET_WORD;
            end else if (hs_ok) begin
                case (src)
                    SRC_SYNC: word_q <= SYNC_WORD;
                    SRC_DP:   word_q <= din[l];
                    SRC_ATU:  word_q <= atu[l];
                    default:  word_q <= IDLE_WORD;
                endcase
            end
        end

        assign dout[l] = word_q;
    end

endmodule

// File: tb/tb_ldtu_link_sequencer.sv
// tb/tb_ldtu_link_sequencer.sv - table-driven self-checking bench for ldtu_link_sequencer
module tb_ldtu_link_sequencer;

    localparam logic [31:0] SW = 32'h5A5A_5A5A;
    localparam logic [31:0] IW = 32'hEAAA_AAAA;
    localparam int K_SYNC = 0;
    localparam int K_DP   = 1;
    localparam int K_ATU  = 2;
    localparam int K_IDLE = 3;

`ifdef LDTU_SYNC_TRAIN_EN
    localparam logic [31:0] RST_WORD = SW;
    localparam logic [1:0]  RST_MODE = 2'd0;
`else
    localparam logic [31:0] RST_WORD = IW;
    localparam logic [1:0]  RST_MODE = 2'd1;
`endif

    logic        clock = 1'b0;
    logic        rst_b = 1'b0;
    logic        handshake = 1'b0;
    logic        test_enable = 1'b0;
    logic        resync = 1'b0;
    logic        dp_valid = 1'b0;
    logic [31:0] din  [4];
    logic [31:0] atu  [4];
    logic [31:0] dout [4];
    logic        dp_ack;
    logic        idle_ins;
    logic [1:0]  mode;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_exp  = 0;

    typedef struct {
        logic        te;
        logic        dv;
        logic [31:0] base;
        int          kind;
        logic [1:0]  m;
        logic        ack;
        logic        idl;
    } vec_t;

    vec_t tbl [12];

    always #5 clock = ~clock;

    ldtu_link_sequencer #(
        .NBITS       (32),
        .SYNC_FRAMES (4),
        .SYNC_WORD   (SW),
        .IDLE_WORD   (IW)
    ) dut (
        .clock       (clock),
        .rst_b       (rst_b),
        .handshake   (handshake),
        .test_enable (test_enable),
        .resync      (resync),
        .dp_valid    (dp_valid),
        .DataIn0     (din[0]),
        .DataIn1     (din[1]),
        .DataIn2     (din[2]),
        .DataIn3     (din[3]),
        .DataAtu0    (atu[0]),
        .DataAtu1    (atu[1]),
        .DataAtu2    (atu[2]),
        .DataAtu3    (atu[3]),
        .DataOut0    (dout[0]),
        .DataOut1    (dout[1]),
        .DataOut2    (dout[2]),
        .DataOut3    (dout[3]),
        .dp_ack      (dp_ack),
        .mode        (mode),
        .idle_ins    (idle_ins),
        .frame_cnt   (frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int kind, input logic [31:0] base, input int l);
        case (kind)
            K_SYNC:  return SW;
            K_DP:    return base + 32'(l);
            K_ATU:   return 32'hC0DE_0000 + 32'(l);
            default: return IW;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        for (int l = 0; l < 4; l++) check({tag, "_lane"}, dout[l], RST_WORD);
        check({tag, "_mode"}, 32'(mode), 32'(RST_MODE));
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_dp_ack"}, 32'(dp_ack), 32'd0);
        check({tag, "_idle_ins"}, 32'(idle_ins), 32'd0);
    endtask

    // One isolated strobe, then a quiet cycle checking pulses drop and words hold.
    task automatic frame(input logic te, input logic rs, input logic dv, input logic [31:0] base,
                         input int kind, input logic [1:0] m, input logic ack, input logic idl,
                         input logic clr);
        @(negedge clock);
        test_enable = te;
        resync      = rs;
        dp_valid    = dv;
        for (int l = 0; l < 4; l++) din[l] = base + 32'(l);
        handshake = 1'b1;
        @(negedge clock);
        handshake = 1'b0;
        cnt_exp = clr ? 0 : ((cnt_exp + 1) & 32'hFFFF);
        for (int l = 0; l < 4; l++) check("frame_lane", dout[l], exp_word(kind, base, l));
        check("frame_mode", 32'(mode), 32'(m));
        check("frame_dp_ack", 32'(dp_ack), 32'(ack));
        check("frame_idle_ins", 32'(idle_ins), 32'(idl));
        check("frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
        for (int l = 0; l < 4; l++) din[l] = ~base;
        @(negedge clock);
        check("pulse_dp_ack_low", 32'(dp_ack), 32'd0);
        check("pulse_idle_ins_low", 32'(idle_ins), 32'd0);
        check("hold_lane0", dout[0], exp_word(kind, base, 0));
        check("hold_mode", 32'(mode), 32'(m));
    endtask

    initial begin
        for (int l = 0; l < 4; l++) begin
            din[l] = 32'd0;
            atu[l] = 32'hC0DE_0000 + 32'(l);
        end

        tbl[0]  = '{1'b0, 1'b1, 32'h1234_5678, K_DP,   2'd1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_1000, K_IDLE, 2'd1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_2000, K_IDLE, 2'd3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'h0000_3000, K_ATU,  2'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_4000, K_ATU,  2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_5000, K_IDLE, 2'd3, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_6000, K_ATU,  2'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_7000, K_IDLE, 2'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hA000_0000, K_DP,   2'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0000_9000, K_IDLE, 2'd1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_A000, K_IDLE, 2'd3, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'hBEEF_0000, K_DP,   2'd1, 1'b1, 1'b0};

        repeat (3) @(negedge clock);
        check_reset_values("reset");

        // A strobe on the reset-release edge must be dropped.
        rst_b     = 1'b1;
        handshake = 1'b1;
        @(negedge clock);
        handshake = 1'b0;
        check("release_hs_frame_cnt", 32'(frame_cnt), 32'd0);
        check("release_hs_lane0", dout[0], RST_WORD);
        check("release_hs_mode", 32'(mode), 32'(RST_MODE));

`ifdef LDTU_SYNC_TRAIN_EN
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd1, 1'b0, 1'b0, 1'b0);
        check("train_frame_cnt", 32'(frame_cnt), 32'd4);
`endif

        for (int i = 0; i < 12; i++) begin
            frame(tbl[i].te, 1'b0, tbl[i].dv, tbl[i].base, tbl[i].kind, tbl[i].m,
                  tbl[i].ack, tbl[i].idl, 1'b0);
        end

        // Back-to-back strobes in DATA: one ack and one new word per cycle.
        @(negedge clock);
        test_enable = 1'b0;
        dp_valid    = 1'b1;
        din[0]      = 32'd100;
        handshake   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            cnt_exp = (cnt_exp + 1) & 32'hFFFF;
            check("b2b_lane0", dout[0], 32'd100 + 32'(k));
            check("b2b_dp_ack", 32'(dp_ack), 32'd1);
            check("b2b_frame_cnt", 32'(frame_cnt), 32'(cnt_exp));
            if (k < 4) din[0] = 32'd101 + 32'(k);
            else handshake = 1'b0;
        end
        @(negedge clock);
        check("b2b_dp_ack_end", 32'(dp_ack), 32'd0);

`ifdef LDTU_SYNC_TRAIN_EN
        // resync wins over a test_enable change; held resync in SYNC does not restart.
        frame(1'b1, 1'b1, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b1, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1, 32'h0, K_SYNC, 2'd1, 1'b0, 1'b0, 1'b0);
`endif

        frame(1'b1, 1'b0, 1'b1, 32'h0000_C000, K_IDLE, 2'd3, 1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b0, 1'b1, 32'h0000_D000, K_ATU,  2'd2, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-TEST, checked before any clock edge.
        #2;
        rst_b = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        rst_b       = 1'b1;
        test_enable = 1'b0;
        dp_valid    = 1'b1;
        repeat (2) @(negedge clock);

        handshake = 1'b1;
        repeat (65535) @(negedge clock);
        check("wrap_ffff", 32'(frame_cnt), 32'h0000_FFFF);
        @(negedge clock);
        handshake = 1'b0;
        check("wrap_zero", 32'(frame_cnt), 32'd0);
        check("wrap_mode", 32'(mode), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ldtu_link_sequencer.md
# ldtu_link_sequencer

Output-link sequencer for the LiTE-DTU. It sits between the datapath/ADC-test-unit word sources and the four-lane serializer. On every serializer `handshake` frame strobe it selects which 32-bit words are loaded on the four lanes: training sync words, compressed datapath words, ADC test-unit words, or idle fill. It also owns the mode switches between these sources, making each switch frame-aligned and glitch-free.

## Interface
Parameters:
- `NBITS`, 32: lane word width.
- `SYNC_FRAMES`, 64: number of sync frames sent per training run, from 1 to 65535.
- `SYNC_WORD`, 32'h5A5A_5A5A: training word, the same on all lanes.
- `IDLE_WORD`, 32'hEAAA_AAAA: fill word, the same on all lanes.

Ports:
- `clock` in 1: single clock (serializer clock domain).
- `rst_b` in 1: reset, asynchronous, active-low.
- `handshake` in 1: one-cycle frame-boundary strobe from the serializers.
- `test_enable` in 1: selects the ADC test-unit source; static between frames.
- `resync` in 1: level request to re-run training.
- `dp_valid` in 1: `DataIn0..3` hold a valid datapath frame.
- `DataIn0`..`DataIn3` in NBITS each: datapath lane words.
- `DataAtu0`..`DataAtu3` in NBITS each: ADC test-unit lane words.
- `DataOut0`..`DataOut3` out NBITS each: registered words to serializer lanes.
- `dp_ack` out 1: one-cycle pulse; datapath frame consumed.
- `mode` out 2: current state; 0 = SYNC, 1 = DATA, 2 = TEST, 3 = SWITCH.
- `idle_ins` out 1: one-cycle pulse; idle frame inserted in DATA because of underrun.
- `frame_cnt` out 16: count of handshakes since reset or resync.

## Operation
- All decisions are taken only in a cycle where `handshake` = 1. Between strobes, outputs and state hold.
- **SYNC state:** load `SYNC_WORD` on all lanes and increment the sync counter. On the handshake that loads the `SYNC_FRAMES`-th sync word, the next state is DATA if `test_enable` = 0, else TEST. There is no SWITCH frame on this transition.
- **DATA state:**
  - `dp_valid` = 1: load `DataIn0..3` and pulse `dp_ack`.
  - `dp_valid` = 0: load `IDLE_WORD` and pulse `idle_ins`.
- **TEST state:** load `DataAtu0..3`. `dp_valid` is ignored and `dp_ack` is never asserted.
- **SWITCH state:** entered from DATA or TEST when the sampled `test_enable` disagrees with the current state. It loads `IDLE_WORD` for exactly one frame, then goes to the state selected by `test_enable` sampled at that next handshake. If `test_enable` has reverted by then, it returns to the original state.
- **resync:** if `resync` = 1 at a handshake in any state other than SYNC, that frame already loads `SYNC_WORD`. The next state is SYNC, the sync counter restarts at 1 and `frame_cnt` clears to 0. `resync` held high in SYNC does not restart training.
- **Priority at one handshake:** resync > training completion > test_enable change > data/idle selection.
- **Counters:**
  - `frame_cnt` increments by 1 per handshake and wraps from 0xFFFF to 0x0000.
  - The sync counter is 16 bits, with saturating compare against `SYNC_FRAMES`.

## Timing
- Inputs are sampled on the rising `clock` edge where `handshake` = 1. `DataOut*`, `mode`, `frame_cnt`, `dp_ack` and `idle_ins` update on that same edge, so they are visible in the following cycle (latency 1).
- `dp_ack` and `idle_ins` are high for exactly one cycle and are mutually exclusive.
- Back-to-back handshakes (every cycle) must be supported with no lost frames.
- **Reset values with `SYNC_TRAIN_EN`:** `DataOut*` = `SYNC_WORD`, `mode` = 0, `frame_cnt` = 0, `dp_ack` = 0, `idle_ins` = 0.
- **Reset values without `SYNC_TRAIN_EN`:** `DataOut*` = `IDLE_WORD`, `mode` = 1, counters 0, pulses 0.
- **Reset mid-operation:** all state is cleared immediately on `rst_b` falling. A handshake coinciding with reset deassertion is ignored.

## Configuration
- Macro: `LDTU_SYNC_TRAIN_EN`.
- **Defined:**
  - The SYNC state exists and is entered at reset and on `resync`.
  - Behaviour is as described above.
- **Undefined:**
  - The SYNC state and sync counter are removed and `resync` is ignored.
  - Reset enters DATA; `mode` never reads 0.
  - `SYNC_WORD` is unused.

## Structure
- Package `ldtu_link_pkg`:
  - state enum (SYNC, DATA, TEST, SWITCH) with the fixed 2-bit `mode` encoding;
  - default `SYNC_WORD` and `IDLE_WORD` constants;
  - lane count constant (4).
- Sub-module `ldtu_sync_frame_ctr`: 16-bit counter with clear, enable and a terminal flag at `SYNC_FRAMES`. It is instantiated only under `LDTU_SYNC_TRAIN_EN`.
- The lane multiplexing is a generate loop over 4 lanes in the top module.

## Test plan
- **Reset and training:** reset with `SYNC_FRAMES` = 4, then 4 handshakes, with `test_enable` = 0 → 4 frames of `5A5A5A5A` on all lanes, then `mode` = 1 and `frame_cnt` = 4.
- **Data and underrun:** in DATA, present `dp_valid` = 1 with `DataIn0` = 32'h12345678 at a handshake → `DataOut0` = 12345678 and `dp_ack` pulses. At the next handshake, `dp_valid` = 0 → `EAAAAAAA` on all lanes and `idle_ins` pulses.
- **Mode switch:** raise `test_enable` between handshakes → the next frame is `IDLE_WORD` with `mode` = 3, the following frame carries `DataAtu*` with `mode` = 2, and `dp_ack` stays 0.
- **Simultaneous events:** `resync` and a `test_enable` change at the same handshake → `SYNC_WORD` is loaded, `mode` = 0, `frame_cnt` = 0, and no SWITCH frame appears.
- **Counter wrap:** force 65536 handshakes without resync → `frame_cnt` wraps to 0.
- **Reset mid-operation:** assert `rst_b` = 0 mid-TEST → outputs return immediately to the reset values.
- **Back-to-back strobes:** apply `handshake` every cycle in DATA with valid data → one `dp_ack` per cycle and no frames lost.
